hv_reg_slv: RTL and testbench

- Register-bank responder at the far end of the HV register access bus; consumes ren/wen/addr/wdata/wcrc from the access arbiter and returns wack/rack/rdata/rcrc.
- Each write is checked against its CRC before commit.
- Writes to the protected address range are gated by a two-key unlock state machine with an inactivity timeout.
- Register contents are exported flat to downstream HV logic.

---
 rtl/hv_reg_pkg.sv | 19 +
 rtl/hv_reg_crc8.sv | 22 ++
 rtl/hv_reg_slv.sv | 171 +++++++++++++++++
 tb/tb_hv_reg_slv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hv_reg_pkg.sv
// Shared constants for the HV register slave: lock states, unlock keys, CRC-8 setup, fixed addresses.
package hv_reg_pkg;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'b00,
      ST_KEY1     = 2'b01,
      ST_UNLOCKED = 2'b10
   } lock_st_e;

   localparam logic [7:0] KEY1_VAL = 8'h5A;
   localparam logic [7:0] KEY2_VAL = 8'hA5;

   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'hFF;

   localparam int ADDR_ID     = 0;
   localparam int ADDR_STATUS = 1;

endpackage

// File: rtl/hv_reg_crc8.sv
// Combinational CRC-8 (poly 0x07, init 0xFF), MSB-first over a DW-bit vector.
// Zero latency, no flow control.
module hv_reg_crc8
   import hv_reg_pkg::*;
#(
   parameter int DW = 15
)(
   input  logic [DW-1:0] dat,
   output logic [7:0]    crc
);

   always_comb begin
      crc = CRC_INIT;
      for (int i = DW - 1; i >= 0; i--) begin
         if (crc[7] ^ dat[i])
            crc = {crc[6:0], 1'b0} ^ CRC_POLY;
         else
            crc = {crc[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/hv_reg_slv.sv
// HV register bank responder: CRC-checked writes, key-unlocked protected range, registered reads.
// Write ack is combinational; read ack/data one cycle after ren; never stalls the access bus.
module hv_reg_slv
   import hv_reg_pkg::*;
#(
   parameter int                REG_AW    = 7,
   parameter int                REG_DW    = 8,
   parameter int                REG_CRC_W = 8,
   parameter int                REG_NUM   = 32,
   parameter int                PROT_BASE = 16,
   parameter int                KEY_ADDR  = 2,
   parameter logic [REG_DW-1:0] ID_VAL    = 8'hA1,
   parameter int                UNLOCK_TO = 1024
)(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_rac_reg_ren,
   input  logic                      i_rac_reg_wen,
   input  logic [REG_AW-1:0]         i_rac_reg_addr,
   input  logic [REG_DW-1:0]         i_rac_reg_wdata,
   input  logic [REG_CRC_W-1:0]      i_rac_reg_wcrc,
   output logic                      o_reg_rac_wack,
   output logic                      o_reg_rac_rack,
   output logic [REG_DW-1:0]         o_reg_rac_rdata,
   output logic [REG_CRC_W-1:0]      o_reg_rac_rcrc,
   output logic [REG_NUM*REG_DW-1:0] o_reg_bank,
   output logic [1:0]                o_lock_st,
   output logic                      o_crc_err
);

   localparam int IDX_W = $clog2(REG_NUM);
   localparam int TO_W  = $clog2(UNLOCK_TO);

   logic [REG_DW-1:0]    reg_q [REG_NUM];
   lock_st_e             lock_st;
   logic [TO_W-1:0]      idle_cnt;
   logic [3:0]           err_cnt;
   logic                 crc_err_q;
   logic                 rack_q;
   logic [REG_DW-1:0]    rdata_q;
   logic [REG_CRC_W-1:0] rcrc_q;

   logic [REG_CRC_W-1:0] wcrc_calc;
   logic [REG_CRC_W-1:0] rcrc_calc;
   logic [REG_DW-1:0]    rd_val;
   logic [IDX_W-1:0]     idx;
   logic                 crc_ok, wr_good, in_range, is_key, is_id, is_status, is_prot;
   logic                 commit, prot_commit;

   hv_reg_crc8 #(.DW(REG_AW + REG_DW)) u_wcrc (
      .dat ({i_rac_reg_addr, i_rac_reg_wdata}),
      .crc (wcrc_calc)
   );

   hv_reg_crc8 #(.DW(REG_AW + REG_DW)) u_rcrc (
      .dat ({i_rac_reg_addr, rd_val}),
      .crc (rcrc_calc)
   );

   assign idx       = i_rac_reg_addr[IDX_W-1:0];
   assign crc_ok    = (wcrc_calc == i_rac_reg_wcrc);
   assign wr_good   = i_rac_reg_wen & crc_ok;
   assign in_range  = (i_rac_reg_addr < REG_AW'(REG_NUM));
   assign is_key    = (i_rac_reg_addr == REG_AW'(KEY_ADDR));
   assign is_id     = (i_rac_reg_addr == REG_AW'(ADDR_ID));
   assign is_status = (i_rac_reg_addr == REG_AW'(ADDR_STATUS));
   assign is_prot   = in_range & (i_rac_reg_addr >= REG_AW'(PROT_BASE));

   // ID, STATUS and KEY are never stored, so their bank slots stay zero.
   assign commit      = wr_good & in_range & ~is_id & ~is_status & ~is_key &
                        (~is_prot | (lock_st == ST_UNLOCKED));
   assign prot_commit = commit & is_prot;

   always_comb begin
      rd_val = '0;
      if (in_range && !is_key) begin
         if (is_id)
            rd_val = ID_VAL;
         else if (is_status)
            rd_val = REG_DW'({err_cnt, 2'b00, lock_st});
         else
            rd_val = reg_q[idx];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < REG_NUM; i++) reg_q[i] <= '0;
      end else if (commit) begin
         reg_q[idx] <= i_rac_reg_wdata;
      end
   end

   // Bad-CRC writes are invisible to the FSM; only wr_good drives transitions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lock_st  <= ST_LOCKED;
         idle_cnt <= '0;
      end else begin
         case (lock_st)
            ST_LOCKED: begin
               idle_cnt <= '0;
               if (wr_good && is_key && i_rac_reg_wdata == REG_DW'(KEY1_VAL))
                  lock_st <= ST_KEY1;
            end
            ST_KEY1: begin
               idle_cnt <= '0;
               if (wr_good)
                  lock_st <= (is_key && i_rac_reg_wdata == REG_DW'(KEY2_VAL)) ? ST_UNLOCKED : ST_LOCKED;
            end
            ST_UNLOCKED: begin
               if (wr_good && is_key) begin
                  lock_st  <= ST_LOCKED;
                  idle_cnt <= '0;
               end else if (prot_commit) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == TO_W'(UNLOCK_TO - 1)) begin
                  lock_st  <= ST_LOCKED;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: begin
               lock_st  <= ST_LOCKED;
               idle_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_cnt   <= '0;
         crc_err_q <= 1'b0;
      end else begin
         crc_err_q <= i_rac_reg_wen & ~crc_ok;
         if (i_rac_reg_wen && !crc_ok) begin
            if (err_cnt != 4'hF) err_cnt <= err_cnt + 1'b1;
         end else if (wr_good && is_status) begin
            err_cnt <= '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rack_q  <= 1'b0;
         rdata_q <= '0;
         rcrc_q  <= '0;
      end else begin
         rack_q <= i_rac_reg_ren;
         if (i_rac_reg_ren) begin
            rdata_q <= rd_val;
            rcrc_q  <= rcrc_calc;
         end
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_bank
      assign o_reg_bank[g*REG_DW +: REG_DW] = reg_q[g];
   end

   assign o_reg_rac_wack  = i_rac_reg_wen;
   assign o_reg_rac_rack  = rack_q;
   assign o_reg_rac_rdata = rdata_q;
   assign o_reg_rac_rcrc  = rcrc_q;
   assign o_lock_st       = lock_st;
   assign o_crc_err       = crc_err_q;

endmodule

// File: tb/tb_hv_reg_slv.sv
// Directed bench for hv_reg_slv: vector table for single accesses plus hand sequences for timing corners.
module tb_hv_reg_slv;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ren = 1'b0;
   logic         wen = 1'b0;
   logic [6:0]   addr = '0;
   logic [7:0]   wdata = '0;
   logic [7:0]   wcrc = '0;
   logic         wack, rack, crc_err;
   logic [7:0]   rdata, rcrc;
   logic [255:0] bank;
   logic [1:0]   lock;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hv_reg_slv dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_rac_reg_ren   (ren),
      .i_rac_reg_wen   (wen),
      .i_rac_reg_addr  (addr),
      .i_rac_reg_wdata (wdata),
      .i_rac_reg_wcrc  (wcrc),
      .o_reg_rac_wack  (wack),
      .o_reg_rac_rack  (rack),
      .o_reg_rac_rdata (rdata),
      .o_reg_rac_rcrc  (rcrc),
      .o_reg_bank      (bank),
      .o_lock_st       (lock),
      .o_crc_err       (crc_err)
   );

   typedef struct {
      bit         is_rd;
      bit         bad;
      logic [6:0] a;
      logic [7:0] d;
      logic [7:0] exp;
      logic [1:0] exp_lock;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] crc8(input logic [14:0] v);
      logic [7:0] c;
      c = 8'hFF;
      for (int i = 14; i >= 0; i--) begin
         if (c[7] ^ v[i]) c = {c[6:0], 1'b0} ^ 8'h07;
         else             c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic vec_t mk(input bit r, input bit b, input logic [6:0] a,
                               input logic [7:0] d, input logic [7:0] e, input logic [1:0] l);
      vec_t v;
      v.is_rd = r; v.bad = b; v.a = a; v.d = d; v.exp = e; v.exp_lock = l;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_wr(input logic [6:0] a, input logic [7:0] d, input bit bad);
      @(negedge clk);
      wen = 1'b1; addr = a; wdata = d;
      wcrc = crc8({a, d}) ^ {7'b0, bad};
      #1 chk("wack", {31'b0, wack}, 32'd1);
      @(negedge clk);
      wen = 1'b0;
      chk("crc_err", {31'b0, crc_err}, {31'b0, bad});
   endtask

   task automatic do_rd(input logic [6:0] a, output logic [7:0] d, output logic [7:0] c);
      @(negedge clk);
      ren = 1'b1; addr = a;
      #1 chk("rack_early", {31'b0, rack}, 32'd0);
      @(negedge clk);
      ren = 1'b0;
      chk("rack", {31'b0, rack}, 32'd1);
      d = rdata; c = rcrc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, c;

      repeat (2) @(negedge clk);
      chk("rst_rack", {31'b0, rack}, 32'd0);
      chk("rst_rdata", {24'b0, rdata}, 32'd0);
      chk("rst_rcrc", {24'b0, rcrc}, 32'd0);
      chk("rst_lock", {30'b0, lock}, 32'd0);
      chk("rst_crc_err", {31'b0, crc_err}, 32'd0);
      chk("rst_bank", {31'b0, bank == '0}, 32'd1);
      rst = 1'b0;

      vecs.push_back(mk(1, 0, 7'd0,  8'h00, 8'hA1, 2'd0));
      vecs.push_back(mk(0, 0, 7'd5,  8'h3C, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd5,  8'h00, 8'h3C, 2'd0));
      vecs.push_back(mk(0, 1, 7'd5,  8'h77, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd5,  8'h00, 8'h3C, 2'd0));
      vecs.push_back(mk(1, 0, 7'd1,  8'h00, 8'h10, 2'd0));
      vecs.push_back(mk(0, 0, 7'd20, 8'h55, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd20, 8'h00, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 7'd2,  8'h5A, 8'h00, 2'd1));
      vecs.push_back(mk(1, 0, 7'd1,  8'h00, 8'h11, 2'd1));
      vecs.push_back(mk(0, 0, 7'd2,  8'hA5, 8'h00, 2'd2));
      vecs.push_back(mk(1, 0, 7'd1,  8'h00, 8'h12, 2'd2));
      vecs.push_back(mk(0, 0, 7'd20, 8'h55, 8'h00, 2'd2));
      vecs.push_back(mk(1, 0, 7'd20, 8'h00, 8'h55, 2'd2));
      vecs.push_back(mk(1, 0, 7'd2,  8'h00, 8'h00, 2'd2));
      vecs.push_back(mk(0, 0, 7'd2,  8'h00, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 7'd2,  8'h5A, 8'h00, 2'd1));
      vecs.push_back(mk(0, 0, 7'd4,  8'h99, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd4,  8'h00, 8'h99, 2'd0));
      vecs.push_back(mk(0, 0, 7'd1,  8'h00, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd1,  8'h00, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd40, 8'h00, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 7'd0,  8'hFF, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd0,  8'h00, 8'hA1, 2'd0));
      vecs.push_back(mk(0, 0, 7'd3,  8'hC3, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd3,  8'h00, 8'hC3, 2'd0));
      vecs.push_back(mk(0, 1, 7'd2,  8'h5A, 8'h00, 2'd0));
      vecs.push_back(mk(1, 0, 7'd1,  8'h00, 8'h10, 2'd0));

      foreach (vecs[i]) begin
         if (vecs[i].is_rd) begin
            do_rd(vecs[i].a, d, c);
            chk($sformatf("v%0d_rdata", i), {24'b0, d}, {24'b0, vecs[i].exp});
            chk($sformatf("v%0d_rcrc", i), {24'b0, c}, {24'b0, crc8({vecs[i].a, vecs[i].exp})});
         end else begin
            do_wr(vecs[i].a, vecs[i].d, vecs[i].bad);
         end
         chk($sformatf("v%0d_lock", i), {30'b0, lock}, {30'b0, vecs[i].exp_lock});
      end

      chk("bank5",  {24'b0, bank[47:40]},   32'h3C);
      chk("bank20", {24'b0, bank[167:160]}, 32'h55);
      chk("bank4",  {24'b0, bank[39:32]},   32'h99);
      chk("bank3",  {24'b0, bank[31:24]},   32'hC3);
      chk("bank0",  {24'b0, bank[7:0]},     32'h00);
      chk("bank2",  {24'b0, bank[23:16]},   32'h00);

      // Error counter saturates at 15 and a good STATUS write clears it.
      repeat (16) do_wr(7'd5, 8'h01, 1'b1);
      do_rd(7'd1, d, c);
      chk("err_sat", {24'b0, d}, 32'hF0);
      do_wr(7'd1, 8'h00, 1'b0);
      do_rd(7'd1, d, c);
      chk("err_clr", {24'b0, d}, 32'h00);

      // Simultaneous read and write: read sees old data, write lands.
      do_wr(7'd6, 8'h11, 1'b0);
      @(negedge clk);
      ren = 1'b1; wen = 1'b1; addr = 7'd6; wdata = 8'h22; wcrc = crc8({7'd6, 8'h22});
      #1 chk("sim_wack", {31'b0, wack}, 32'd1);
      @(negedge clk);
      ren = 1'b0; wen = 1'b0;
      chk("sim_rack", {31'b0, rack}, 32'd1);
      chk("sim_rdata", {24'b0, rdata}, 32'h11);
      chk("sim_rcrc", {24'b0, rcrc}, {24'b0, crc8({7'd6, 8'h11})});
      chk("sim_bank6", {24'b0, bank[55:48]}, 32'h22);

      // Read in the cycle right after a write returns the new value.
      @(negedge clk);
      wen = 1'b1; addr = 7'd7; wdata = 8'h5E; wcrc = crc8({7'd7, 8'h5E});
      @(negedge clk);
      wen = 1'b0; ren = 1'b1;
      chk("b2b_bank7", {24'b0, bank[63:56]}, 32'h5E);
      @(negedge clk);
      ren = 1'b0;
      chk("b2b_rack", {31'b0, rack}, 32'd1);
      chk("b2b_rdata", {24'b0, rdata}, 32'h5E);

      // Inactivity timeout: unlocked for exactly UNLOCK_TO cycles after the unlock commit.
      do_wr(7'd2, 8'h5A, 1'b0);
      do_wr(7'd2, 8'hA5, 1'b0);
      chk("to_unlocked", {30'b0, lock}, 32'd2);
      repeat (1023) @(posedge clk);
      @(negedge clk);
      chk("to_still_unlocked", {30'b0, lock}, 32'd2);
      @(negedge clk);
      chk("to_relocked", {30'b0, lock}, 32'd0);
      do_wr(7'd20, 8'h66, 1'b0);
      do_rd(7'd20, d, c);
      chk("to_prot_dropped", {24'b0, d}, 32'h55);

      // Reset landing on a pending read drops the ack.
      @(negedge clk);
      ren = 1'b1; addr = 7'd0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1 chk("rstrd_rack_edge", {31'b0, rack}, 32'd0);
      @(negedge clk);
      ren = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("rstrd_rack", {31'b0, rack}, 32'd0);
      chk("rstrd_rdata", {24'b0, rdata}, 32'd0);
      chk("rstrd_bank", {31'b0, bank == '0}, 32'd1);
      chk("rstrd_lock", {30'b0, lock}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
